// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the execute stage and the data memory port. An aligned access is
// accepted in IDLE, its bus fields are registered, and a req/gnt/rvalid
// handshake is run with data memory. Load data is shifted down to bit 0 and
// sign- or zero-extended before it is handed to the register-file write mux.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   lsu_req_i .. wdata_i    access request from execute (held while busy)
//   lsu_busy_o              stall request to the core
//   lsu_rvalid_o            access completes this cycle (pulse)
//   lsu_rdata_o             extended load data (0 outside a load completion)
//   misaligned_o            access rejected: misaligned or illegal size (pulse)
//   err_o                   bus error on the completing access (pulse)
//   data_*                  data memory request/response port
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_size_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_busy_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  misaligned_o,
  output logic                  err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_err_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;

  logic                  misaligned_s;
  logic                  complete_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] ext_s;

  // Alignment check on the incoming request; size 11 is never legal.
  always_comb begin
    misaligned_s = 1'b0;
    case (lsu_size_i)
      2'b00:   misaligned_s = 1'b0;
      2'b01:   misaligned_s = lsu_addr_i[0];
      2'b10:   misaligned_s = (lsu_addr_i[1:0] != 2'b00);
      default: misaligned_s = 1'b1;
    endcase
  end

  // Next-state and request-field capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    size_d  = size_q;
    sext_d  = sext_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i && !misaligned_s) begin
          state_d = REQ;
          addr_d  = {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
          we_d    = lsu_we_i;
          off_d   = lsu_addr_i[1:0];
          size_d  = lsu_size_i;
          sext_d  = lsu_sign_ext_i;
          case (lsu_size_i)
            2'b00: begin
              be_d    = 4'b0001 << lsu_addr_i[1:0];
              wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
              be_d    = 4'b0011 << lsu_addr_i[1:0];
              wdata_d = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
              be_d    = 4'b1111;
              wdata_d = lsu_wdata_i;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (data_rvalid_i) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus-field registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= {DATA_WIDTH{1'b0}};
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
    end
  end

  assign data_req_o   = (state_q == REQ);
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

  assign complete_s = (state_q == WAIT) && data_rvalid_i;

  // Bring the addressed byte/half down to bit 0, then extend.
  assign shifted_s = data_rdata_i >> {off_q, 3'b000};

  // Load extension by latched size.
  always_comb begin
    ext_s = shifted_s;
    case (size_q)
      2'b00:   ext_s = {{24{sext_q & shifted_s[7]}}, shifted_s[7:0]};
      2'b01:   ext_s = {{16{sext_q & shifted_s[15]}}, shifted_s[15:0]};
      default: ext_s = shifted_s;
    endcase
  end

  // Core-facing status; completion and rejection are same-cycle pulses.
  always_comb begin
    lsu_busy_o   = 1'b0;
    lsu_rvalid_o = 1'b0;
    lsu_rdata_o  = {DATA_WIDTH{1'b0}};
    misaligned_o = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          misaligned_o = misaligned_s;
          lsu_busy_o   = !misaligned_s;
        end else begin
          misaligned_o = 1'b0;
        end
      end
      REQ:  lsu_busy_o = 1'b1;
      WAIT: begin
        lsu_busy_o = !data_rvalid_i;
        if (complete_s) begin
          lsu_rvalid_o = 1'b1;
          err_o        = data_err_i;
          // Stores and errored accesses return zero.
          if (we_q || data_err_i) begin
            lsu_rdata_o = {DATA_WIDTH{1'b0}};
          end else begin
            lsu_rdata_o = ext_s;
          end
        end else begin
          lsu_rvalid_o = 1'b0;
        end
      end
      default: lsu_busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_rvalid_o, misaligned_o, err_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .misaligned_o(misaligned_o), .err_o(err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          gnt_dly;
    int          rv_dly;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_sign_ext_i = 1'b0;
    lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"},   {31'b0, lsu_busy_o},   32'h0);
    chk({tag, ".rvalid"}, {31'b0, lsu_rvalid_o}, 32'h0);
    chk({tag, ".rdata"},  lsu_rdata_o,           32'h0);
    chk({tag, ".mis"},    {31'b0, misaligned_o}, 32'h0);
    chk({tag, ".err"},    {31'b0, err_o},        32'h0);
    chk({tag, ".req"},    {31'b0, data_req_o},   32'h0);
    chk({tag, ".we"},     {31'b0, data_we_o},    32'h0);
    chk({tag, ".be"},     {28'b0, data_be_o},    32'h0);
    chk({tag, ".addr"},   data_addr_o,           32'h0);
    chk({tag, ".wdata"},  data_wdata_o,          32'h0);
  endtask

  // Drives one access: inputs change on negedge, outputs sampled 1ns later.
  task automatic run_vec(input vec_t v);
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = v.we; lsu_size_i = v.size; lsu_sign_ext_i = v.sext;
    lsu_addr_i = v.addr; lsu_wdata_i = v.wdata;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    #1;
    if (v.exp_mis) begin
      chk({v.name, ".mis"},  {31'b0, misaligned_o}, 32'h1);
      chk({v.name, ".busy"}, {31'b0, lsu_busy_o},   32'h0);
      chk({v.name, ".req0"}, {31'b0, data_req_o},   32'h0);
      @(negedge clk_i);
      lsu_req_i = 1'b0;
      #1;
      chk({v.name, ".mis_pulse"}, {31'b0, misaligned_o}, 32'h0);
      chk({v.name, ".req1"},      {31'b0, data_req_o},   32'h0);
      return;
    end
    chk({v.name, ".acc_busy"}, {31'b0, lsu_busy_o},   32'h1);
    chk({v.name, ".acc_mis"},  {31'b0, misaligned_o}, 32'h0);
    chk({v.name, ".acc_req"},  {31'b0, data_req_o},   32'h0);
    for (int i = 0; i <= v.gnt_dly; i++) begin
      @(negedge clk_i);
      data_gnt_i = (i == v.gnt_dly);
      #1;
      chk({v.name, ".req"},   {31'b0, data_req_o},   32'h1);
      chk({v.name, ".addr"},  data_addr_o,           v.exp_addr);
      chk({v.name, ".be"},    {28'b0, data_be_o},    {28'b0, v.exp_be});
      chk({v.name, ".we"},    {31'b0, data_we_o},    {31'b0, v.we});
      chk({v.name, ".wdata"}, data_wdata_o,          v.exp_wdata);
      chk({v.name, ".rbusy"}, {31'b0, lsu_busy_o},   32'h1);
    end
    for (int i = 0; i <= v.rv_dly; i++) begin
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      data_rvalid_i = (i == v.rv_dly);
      data_err_i = (i == v.rv_dly) ? v.err : 1'b0;
      data_rdata_i = v.rdata;
      #1;
      chk({v.name, ".wreq"}, {31'b0, data_req_o}, 32'h0);
      if (i < v.rv_dly) begin
        chk({v.name, ".wbusy"},   {31'b0, lsu_busy_o},   32'h1);
        chk({v.name, ".wrvalid"}, {31'b0, lsu_rvalid_o}, 32'h0);
      end else begin
        chk({v.name, ".cbusy"},   {31'b0, lsu_busy_o},   32'h0);
        chk({v.name, ".crvalid"}, {31'b0, lsu_rvalid_o}, 32'h1);
        chk({v.name, ".crdata"},  lsu_rdata_o,           v.exp_rdata);
        chk({v.name, ".cerr"},    {31'b0, err_o},        {31'b0, v.err});
      end
    end
    @(negedge clk_i);
    lsu_req_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    #1;
    chk({v.name, ".pbusy"},   {31'b0, lsu_busy_o},   32'h0);
    chk({v.name, ".prvalid"}, {31'b0, lsu_rvalid_o}, 32'h0);
    chk({v.name, ".prdata"},  lsu_rdata_o,           32'h0);
    chk({v.name, ".perr"},    {31'b0, err_o},        32'h0);
  endtask

  initial begin
    //            name    we    size   sx    addr          wdata         rdata         err  g  r  mis   exp_addr      be       exp_wdata     exp_rdata
    vecs[0]  = '{"lw",   1'b0, 2'b10, 1'b0, 32'h00000100, 32'h11223344, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0, 32'h00000100, 4'b1111, 32'h11223344, 32'hDEADBEEF};
    vecs[1]  = '{"lb",   1'b0, 2'b00, 1'b1, 32'h00000103, 32'h00000000, 32'h80FF1234, 1'b0, 0, 0, 1'b0, 32'h00000100, 4'b1000, 32'h00000000, 32'hFFFFFF80};
    vecs[2]  = '{"lbu",  1'b0, 2'b00, 1'b0, 32'h00000103, 32'h00000000, 32'h80FF1234, 1'b0, 0, 0, 1'b0, 32'h00000100, 4'b1000, 32'h00000000, 32'h00000080};
    vecs[3]  = '{"lh",   1'b0, 2'b01, 1'b1, 32'h00000102, 32'h00000000, 32'h80FF1234, 1'b0, 0, 0, 1'b0, 32'h00000100, 4'b1100, 32'h00000000, 32'hFFFF80FF};
    vecs[4]  = '{"sh",   1'b1, 2'b01, 1'b0, 32'h00000102, 32'h0000ABCD, 32'h55555555, 1'b0, 3, 0, 1'b0, 32'h00000100, 4'b1100, 32'hABCDABCD, 32'h00000000};
    vecs[5]  = '{"lwerr",1'b0, 2'b10, 1'b0, 32'h00000100, 32'h00000000, 32'hCAFEF00D, 1'b1, 0, 0, 1'b0, 32'h00000100, 4'b1111, 32'h00000000, 32'h00000000};
    vecs[6]  = '{"lwmis",1'b0, 2'b10, 1'b0, 32'h00000102, 32'h00000000, 32'h00000000, 1'b0, 0, 0, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000};
    vecs[7]  = '{"sz11", 1'b0, 2'b11, 1'b0, 32'h00000100, 32'h00000000, 32'h00000000, 1'b0, 0, 0, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000};
    vecs[8]  = '{"sb",   1'b1, 2'b00, 1'b0, 32'h00000201, 32'h123456A5, 32'h00000000, 1'b0, 1, 0, 1'b0, 32'h00000200, 4'b0010, 32'hA5A5A5A5, 32'h00000000};
    vecs[9]  = '{"lhu",  1'b0, 2'b01, 1'b0, 32'h00000100, 32'h00000000, 32'h1234F00D, 1'b0, 0, 2, 1'b0, 32'h00000100, 4'b0011, 32'h00000000, 32'h0000F00D};
    vecs[10] = '{"lh0",  1'b0, 2'b01, 1'b1, 32'h00000100, 32'h00000000, 32'h1234F00D, 1'b0, 0, 0, 1'b0, 32'h00000100, 4'b0011, 32'h00000000, 32'hFFFFF00D};
    vecs[11] = '{"lb1",  1'b0, 2'b00, 1'b1, 32'h00000101, 32'h00000000, 32'h1234F00D, 1'b0, 0, 0, 1'b0, 32'h00000100, 4'b0010, 32'h00000000, 32'hFFFFFFF0};
    vecs[12] = '{"lhmis",1'b0, 2'b01, 1'b0, 32'h00000103, 32'h00000000, 32'h00000000, 1'b0, 0, 0, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000};

    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_all_zero("reset");

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
    end

    // Reset while waiting for the response: everything clears next cycle.
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 2'b10; lsu_addr_i = 32'h00000300;
    lsu_wdata_i = 32'h0BADC0DE;
    @(negedge clk_i);
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    #1;
    chk("rstw.inwait_busy", {31'b0, lsu_busy_o}, 32'h1);
    chk("rstw.inwait_we",   {31'b0, data_we_o},  32'h1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    lsu_req_i = 1'b0;
    #1;
    check_all_zero("rstw");

    run_vec('{"lw200", 1'b0, 2'b10, 1'b0, 32'h00000200, 32'h00000000, 32'h0F0F1234, 1'b0, 0, 0, 1'b0,
              32'h00000200, 4'b1111, 32'h00000000, 32'h0F0F1234});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
